// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one vectoring CORDIC unit between two
// requesters. A job is accepted in IDLE, run on the unit in RUN (bounded by
// TIMEOUT cycles), and its result is held in RESP until its owner takes it.
//
// Handshake rule for every port pair: a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer keeps valid high and its
// payload stable until that edge, and never withdraws a pending item.
// req*_ready is decoded from state and the grant, so it may depend on the
// same-cycle valid. rsp*_valid does not depend on rsp*_ready.
module cordic_rr_scheduler #(
  // Maximum RUN cycles before the job is aborted. Legal range is 2..1023.
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic signed [31:0] req0_x,
  input  logic signed [31:0] req0_y,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic signed [31:0] req1_x,
  input  logic signed [31:0] req1_y,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic signed [31:0] rsp_mag,
  output logic signed [31:0] rsp_angle,
  output logic               rsp_err,
  output logic signed [31:0] cu_data_1,
  output logic signed [31:0] cu_data_2,
  output logic               cu_en,
  input  logic signed [31:0] cu_o_data_1,
  input  logic signed [31:0] cu_angle,
  input  logic               cu_done,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter value seen in the last allowed RUN cycle.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic [9:0] cnt;
  logic       grant;
  logic       hs0;
  logic       hs1;
  logic       accept;
  logic       timeout_hit;
  logic       rsp_taken;

  // On a tie the requester that was not served last wins; otherwise the
  // single valid requester wins.
  assign grant       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready  = (state == S_IDLE) && req0_valid && !grant;
  assign req1_ready  = (state == S_IDLE) && req1_valid && grant;
  assign hs0         = req0_valid && req0_ready;
  assign hs1         = req1_valid && req1_ready;
  assign accept      = hs0 || hs1;
  assign timeout_hit = (cnt == CNT_LAST);
  assign rsp_taken   = owner ? rsp1_ready : rsp0_ready;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  // Control FSM: state, ownership, fairness memory, run counter, unit enable
  // and response valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      cu_en      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner <= hs1;
            cnt   <= '0;
            cu_en <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt + 10'd1;
          // A done flag in the final allowed cycle still counts as success.
          if (cu_done || timeout_hit) begin
            cu_en      <= 1'b0;
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_taken) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last_grant <= owner;
            state      <= S_IDLE;
          end
        end
        default: begin
          cu_en      <= 1'b0;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand registers feed the unit directly, result registers feed
  // the shared response buses; each holds its value outside its load point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cu_data_1 <= '0;
      cu_data_2 <= '0;
      rsp_mag   <= '0;
      rsp_angle <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if ((state == S_IDLE) && accept) begin
        cu_data_1 <= hs1 ? req1_x : req0_x;
        cu_data_2 <= hs1 ? req1_y : req0_y;
      end
      if (state == S_RUN) begin
        if (cu_done) begin
          rsp_mag   <= cu_o_data_1;
          rsp_angle <= cu_angle;
          rsp_err   <= 1'b0;
        end else if (timeout_hit) begin
          rsp_mag   <= '0;
          rsp_angle <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler. Two instances are built: u_dut with the
// default TIMEOUT and u_dut_tmo with TIMEOUT=8. The sel signal routes the
// shared requester/responder stimulus and the unit model to one of them.
module tb_cordic_rr_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus / muxed observation ----------------
  logic        sel;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, cu_en, busy, cu_done;
  logic [31:0] rsp_mag, rsp_angle, cu_data_1, cu_data_2, cu_o_data_1, cu_angle;
  logic [1:0]  state_dbg;

  logic        a_req0_valid, a_req1_valid, a_rsp0_ready, a_rsp1_ready, a_cu_done;
  logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rsp_err, a_cu_en, a_busy;
  logic [31:0] a_rsp_mag, a_rsp_angle, a_cu_data_1, a_cu_data_2;
  logic [1:0]  a_state;
  logic        b_req0_valid, b_req1_valid, b_rsp0_ready, b_rsp1_ready, b_cu_done;
  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp_err, b_cu_en, b_busy;
  logic [31:0] b_rsp_mag, b_rsp_angle, b_cu_data_1, b_cu_data_2;
  logic [1:0]  b_state;

  assign a_req0_valid = req0_valid & ~sel;
  assign a_req1_valid = req1_valid & ~sel;
  assign a_rsp0_ready = rsp0_ready & ~sel;
  assign a_rsp1_ready = rsp1_ready & ~sel;
  assign a_cu_done    = cu_done & ~sel;
  assign b_req0_valid = req0_valid & sel;
  assign b_req1_valid = req1_valid & sel;
  assign b_rsp0_ready = rsp0_ready & sel;
  assign b_rsp1_ready = rsp1_ready & sel;
  assign b_cu_done    = cu_done & sel;

  assign req0_ready = sel ? b_req0_ready : a_req0_ready;
  assign req1_ready = sel ? b_req1_ready : a_req1_ready;
  assign rsp0_valid = sel ? b_rsp0_valid : a_rsp0_valid;
  assign rsp1_valid = sel ? b_rsp1_valid : a_rsp1_valid;
  assign rsp_err    = sel ? b_rsp_err    : a_rsp_err;
  assign rsp_mag    = sel ? b_rsp_mag    : a_rsp_mag;
  assign rsp_angle  = sel ? b_rsp_angle  : a_rsp_angle;
  assign cu_en      = sel ? b_cu_en      : a_cu_en;
  assign cu_data_1  = sel ? b_cu_data_1  : a_cu_data_1;
  assign cu_data_2  = sel ? b_cu_data_2  : a_cu_data_2;
  assign busy       = sel ? b_busy       : a_busy;
  assign state_dbg  = sel ? b_state      : a_state;

  cordic_rr_scheduler #(.TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready),
    .rsp_mag(a_rsp_mag), .rsp_angle(a_rsp_angle), .rsp_err(a_rsp_err),
    .cu_data_1(a_cu_data_1), .cu_data_2(a_cu_data_2), .cu_en(a_cu_en),
    .cu_o_data_1(cu_o_data_1), .cu_angle(cu_angle), .cu_done(a_cu_done),
    .busy(a_busy), .state_dbg(a_state)
  );

  cordic_rr_scheduler #(.TIMEOUT(8)) u_dut_tmo (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready),
    .rsp_mag(b_rsp_mag), .rsp_angle(b_rsp_angle), .rsp_err(b_rsp_err),
    .cu_data_1(b_cu_data_1), .cu_data_2(b_cu_data_2), .cu_en(b_cu_en),
    .cu_o_data_1(cu_o_data_1), .cu_angle(cu_angle), .cu_done(b_cu_done),
    .busy(b_busy), .state_dbg(b_state)
  );

  // ---------------- CORDIC unit model ----------------
  // done_lat = N asserts done in the Nth cycle that en is high; 0 = never.
  int done_lat = 3;
  int run_cyc  = 0;

  function automatic logic [31:0] unit_mag(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h0003_0000 && y == 32'h0004_0000) return 32'h0005_0000;
    return x + y;
  endfunction

  function automatic logic [31:0] unit_angle(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h0003_0000 && y == 32'h0004_0000) return 32'h0000_3B58;
    return x ^ y;
  endfunction

  always @(posedge clk) run_cyc <= cu_en ? run_cyc + 1 : 0;
  assign cu_done     = cu_en && (done_lat != 0) && (run_cyc == done_lat - 1);
  assign cu_o_data_1 = unit_mag(cu_data_1, cu_data_2);
  assign cu_angle    = unit_angle(cu_data_1, cu_data_2);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [65:0] exp_q[$];   // {owner, err, mag, angle}
  int grant_q[$];

  function automatic logic [65:0] make_exp(input logic own, input logic [31:0] x, input logic [31:0] y);
    logic err;
    int   tmo;
    tmo = sel ? 8 : 64;
    err = (done_lat == 0) || (done_lat > tmo);
    return {own, err, (err ? 32'd0 : unit_mag(x, y)), (err ? 32'd0 : unit_angle(x, y))};
  endfunction

  task automatic scoreboard_mon();
    logic [65:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (req0_valid && req0_ready) begin
          exp_q.push_back(make_exp(1'b0, req0_x, req0_y));
          grant_q.push_back(0);
        end
        if (req1_valid && req1_ready) begin
          exp_q.push_back(make_exp(1'b1, req1_x, req1_y));
          grant_q.push_back(1);
        end
        if (rsp0_valid && rsp1_valid) begin
          total++; bad++;
          $display("FAIL rsp_exclusive: rsp0_valid=1 rsp1_valid=1 at cycle %0d, want at most one", cyc);
        end
        if (rsp0_valid && rsp0_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_rsp0: response mag=%h with nothing pending", rsp_mag);
          end else begin
            e = exp_q.pop_front();
            if ({1'b0, rsp_err, rsp_mag, rsp_angle} !== e) begin
              bad++;
              $display("FAIL sb_rsp0: got own=0 err=%0d mag=%h ang=%h, want own=%0d err=%0d mag=%h ang=%h",
                       rsp_err, rsp_mag, rsp_angle, e[65], e[64], e[63:32], e[31:0]);
            end
          end
        end
        if (rsp1_valid && rsp1_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_rsp1: response mag=%h with nothing pending", rsp_mag);
          end else begin
            e = exp_q.pop_front();
            if ({1'b1, rsp_err, rsp_mag, rsp_angle} !== e) begin
              bad++;
              $display("FAIL sb_rsp1: got own=1 err=%0d mag=%h ang=%h, want own=%0d err=%0d mag=%h ang=%h",
                       rsp_err, rsp_mag, rsp_angle, e[65], e[64], e[63:32], e[31:0]);
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents one operand pair and returns just after the accepting edge.
  task automatic drive_req(input int who, input logic [31:0] x, input logic [31:0] y);
    int n;
    @(posedge clk); #1;
    if (who == 0) begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    else          begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if ((who == 0) ? req0_ready : req1_ready) break;
    end
    if (n == 500) begin
      total++; bad++;
      $display("FAIL drive_req%0d: ready=0 for 500 cycles, want 1", who);
    end
    @(posedge clk); #1;
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    if (n == 400) begin
      total++; bad++;
      $display("FAIL wait_idle: busy=%0d pending=%0d after 400 cycles, want 0 and 0", busy, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, cu_en, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready, state_dbg} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%0d en=%0d v0=%0d v1=%0d err=%0d r0=%0d r1=%0d st=%0d, want all 0",
               busy, cu_en, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready, state_dbg);
    end
    total++;
    if ({cu_data_1, cu_data_2, rsp_mag, rsp_angle} !== 128'd0) begin
      bad++;
      $display("FAIL reset_data: d1=%h d2=%h mag=%h ang=%h, want 0", cu_data_1, cu_data_2, rsp_mag, rsp_angle);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL reset_tie: r0=%0d r1=%0d, want r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_tie();
    done_lat = 3;
    grant_q.delete();
    fork
      begin for (int j = 0; j < 3; j++) drive_req(0, $urandom, $urandom); end
      begin for (int j = 0; j < 3; j++) drive_req(1, $urandom, $urandom); end
    join
    wait_idle();
    total++;
    if (grant_q.size() !== 6) begin
      bad++;
      $display("FAIL tie_count: %0d grants, want 6", grant_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (grant_q[i] !== (i % 2)) begin
          bad++;
          $display("FAIL tie_order[%0d]: grant=%0d, want %0d", i, grant_q[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_single();
    int en_cnt, lat;
    logic saw1;
    sel = 1'b0; done_lat = 16;
    drive_req(0, 32'h0003_0000, 32'h0004_0000);
    en_cnt = 0; lat = 0; saw1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (cu_en) en_cnt++;
      if (rsp1_valid) saw1 = 1'b1;
      if (rsp0_valid && lat == 0) begin
        lat = c;
        total++;
        if ({rsp_err, rsp_mag, rsp_angle} !== {1'b0, 32'h0005_0000, 32'h0000_3B58}) begin
          bad++;
          $display("FAIL single_value: err=%0d mag=%h ang=%h, want 0 00050000 00003b58", rsp_err, rsp_mag, rsp_angle);
        end
      end
    end
    total++;
    if (lat !== 17) begin bad++; $display("FAIL single_latency: rsp0_valid at cycle %0d, want 17", lat); end
    total++;
    if (en_cnt !== 16) begin bad++; $display("FAIL single_en: cu_en high %0d cycles, want 16", en_cnt); end
    total++;
    if (saw1 !== 1'b0) begin bad++; $display("FAIL single_rsp1: rsp1_valid seen=%0d, want 0", saw1); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] x, y;
    int n;
    sel = 1'b0; done_lat = 5;
    x = $urandom; y = $urandom;
    rsp1_ready = 1'b0;
    drive_req(1, x, y);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp1_valid) break;
    end
    if (n == 100) begin total++; bad++; $display("FAIL bp_wait: rsp1_valid=0 for 100 cycles, want 1"); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_x = $urandom; req0_y = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({rsp1_valid, rsp0_valid, cu_en, req0_ready, busy, rsp_err} !== 6'b100010 ||
          rsp_mag !== unit_mag(x, y) || rsp_angle !== unit_angle(x, y)) begin
        bad++;
        $display("FAIL bp_hold[%0d]: v1=%0d v0=%0d en=%0d r0=%0d busy=%0d err=%0d mag=%h ang=%h, want 1 0 0 0 1 0 %h %h",
                 c, rsp1_valid, rsp0_valid, cu_en, req0_ready, busy, rsp_err, rsp_mag, rsp_angle,
                 unit_mag(x, y), unit_angle(x, y));
      end
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, req0_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: busy=%0d r0=%0d one cycle after take, want 0 1", busy, req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int t_prev, jobs;
    sel = 1'b0; done_lat = 1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_x = $urandom; req0_y = $urandom;
    jobs = 0; t_prev = -1;
    for (int c = 0; c < 40 && jobs < 4; c++) begin
      @(negedge clk);
      if (req0_ready) begin
        total++;
        if (cu_en !== 1'b0) begin bad++; $display("FAIL b2b_en_gap: cu_en=%0d in accept cycle, want 0", cu_en); end
        if (t_prev >= 0) begin
          total++;
          if (cyc - t_prev !== 3) begin bad++; $display("FAIL b2b_period: %0d cycles, want 3", cyc - t_prev); end
        end
        t_prev = cyc; jobs++;
        @(posedge clk); #1;
        if (jobs == 4) req0_valid = 1'b0;
        else begin req0_x = $urandom; req0_y = $urandom; end
      end
    end
    if (jobs != 4) begin total++; bad++; $display("FAIL b2b_jobs: %0d accepted, want 4", jobs); end
    wait_idle();
  endtask

  task automatic test_timeout();
    int en_cnt, lat;
    sel = 1'b1; done_lat = 0;
    drive_req(0, $urandom, $urandom);
    en_cnt = 0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (cu_en) en_cnt++;
      if (rsp0_valid && lat == 0) begin
        lat = c;
        total++;
        if ({rsp_err, rsp_mag, rsp_angle} !== {1'b1, 64'd0}) begin
          bad++;
          $display("FAIL tmo_value: err=%0d mag=%h ang=%h, want 1 0 0", rsp_err, rsp_mag, rsp_angle);
        end
      end
    end
    total++;
    if (en_cnt !== 8) begin bad++; $display("FAIL tmo_en: cu_en high %0d cycles, want 8", en_cnt); end
    total++;
    if (lat !== 9) begin bad++; $display("FAIL tmo_latency: rsp0_valid at cycle %0d, want 9", lat); end
    done_lat = 4;
    drive_req(1, $urandom, $urandom);
    wait_idle();
  endtask

  task automatic test_done_on_timeout();
    int lat;
    sel = 1'b1; done_lat = 8;
    drive_req(1, $urandom, $urandom);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp1_valid && lat == 0) begin
        lat = c;
        total++;
        if (rsp_err !== 1'b0) begin bad++; $display("FAIL edge_err: err=%0d, want 0", rsp_err); end
      end
    end
    total++;
    if (lat !== 9) begin bad++; $display("FAIL edge_latency: rsp1_valid at cycle %0d, want 9", lat); end
    wait_idle();
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b0; done_lat = 0;
    drive_req(0, $urandom, $urandom);
    repeat (5) @(negedge clk);
    total++;
    if ({busy, cu_en} !== 2'b11) begin bad++; $display("FAIL mid_active: busy=%0d en=%0d, want 1 1", busy, cu_en); end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({cu_en, busy, rsp0_valid, rsp1_valid, state_dbg} !== 6'b0) begin
      bad++;
      $display("FAIL mid_async: en=%0d busy=%0d v0=%0d v1=%0d st=%0d, want all 0",
               cu_en, busy, rsp0_valid, rsp1_valid, state_dbg);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({cu_en, rsp0_valid, rsp1_valid, rsp_mag, rsp_angle} !== 67'd0) begin
      bad++;
      $display("FAIL mid_hold: en=%0d v0=%0d v1=%0d mag=%h ang=%h, want 0", cu_en, rsp0_valid, rsp1_valid, rsp_mag, rsp_angle);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL mid_tie: r0=%0d r1=%0d after reset, want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b0; sel = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    fork scoreboard_mon(); join_none
    test_reset();
    test_tie();
    test_single();
    test_back_pressure();
    test_back_to_back();
    test_timeout();
    test_done_on_timeout();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
